// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the ALU, the result queue and its downstream consumer.
// The slave modport is the queue's view; the master modport is the view of the surrounding logic.
interface alu_result_queue_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_sel;
  logic [7:0] in_y;
  logic       in_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic [2:0] out_sel;
  logic [3:0] out_flags;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_y, in_cout, out_ready,
    output in_ready, out_valid, out_y, out_sel, out_flags
  );
  modport master (
    output in_valid, in_a, in_b, in_sel, in_y, in_cout, out_ready,
    input  in_ready, out_valid, out_y, out_sel, out_flags
  );
endinterface

// File: rtl/alu_result_queue.sv
// Registered ALU result FIFO: stores result, opcode and derived {V,N,Z,C} flags per entry,
// and keeps a saturating count of pushed entries that signalled signed overflow.
module alu_result_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_queue_if.slave        bus,
  input  logic                     clr_cnt,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               ovf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] sel;
    logic [3:0] flags;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, v;
  logic [3:0]      flags;
  logic            unused_b;

  // Only the sign bit of B participates in the overflow rules.
  assign unused_b = ^bus.in_b[6:0];

  always_comb begin
    v = 1'b0;
    case (bus.in_sel)
      OP_ADD:  v = (bus.in_a[7] == bus.in_b[7]) && (bus.in_y[7] != bus.in_a[7]);
      OP_SUB:  v = (bus.in_a[7] != bus.in_b[7]) && (bus.in_y[7] != bus.in_a[7]);
      OP_INC:  v = (bus.in_a == 8'h7F);
      OP_DEC:  v = (bus.in_a == 8'h80);
      default: v = 1'b0;
    endcase
  end

  assign flags = {v, bus.in_y[7], (bus.in_y == 8'h00), bus.in_cout};

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign bus.in_ready  = (count < CW'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign bus.out_y     = mem[rd_ptr].y;
  assign bus.out_sel   = mem[rd_ptr].sel;
  assign bus.out_flags = mem[rd_ptr].flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{y: bus.in_y, sel: bus.in_sel, flags: flags};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (clr_cnt)                          ovf_cnt <= '0;
      else if (push && v && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Registered result stage directly downstream of the 8-bit combinational ALU. It captures each ALU result (Y, Cout) together with the operands and opcode that produced it, and derives V/N/Z/C status flags. Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It also keeps a saturating count of signed-overflow results for the register file and control logic downstream.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents an ALU result
- in_ready  out  1  queue can accept this cycle
- in_a  in  8  ALU operand A for this result
- in_b  in  8  ALU operand B for this result
- in_sel  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 INC A, 111 DEC A
- in_y  in  8  ALU result
- in_cout  in  1  ALU carry out (borrow for SUB/DEC)
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head
- out_y  out  8  head result
- out_sel  out  3  head opcode
- out_flags  out  4  head flags {V,N,Z,C}
- count  out  clog2(DEPTH)+1  current occupancy
- ovf_cnt  out  8  saturating count of accepted entries with V=1
- clr_cnt  in  1  synchronous clear of ovf_cnt

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (count < DEPTH); it depends on registered count only. A pop in the same cycle does not allow a push when the queue is full.
- out_valid = (count != 0). out_y, out_sel and out_flags come from storage at the read pointer.
- Flags are computed combinationally from in_* at push and stored with the entry:
  - C = in_cout, passed through for every opcode.
  - Z = (in_y == 0).
  - N = in_y[7].
  - V for ADD: (a7 == b7) && (y7 != a7).
  - V for SUB: (a7 != b7) && (y7 != a7).
  - V for INC: in_a == 8'h7F.
  - V for DEC: in_a == 8'h80.
  - V = 0 for all logic opcodes.
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Occupancy updates:
  - Push only: count +1.
  - Pop only: count −1.
  - Push and pop together (only possible when 0 < count < DEPTH): count unchanged, both pointers advance.
- ovf_cnt:
  - Increments by 1 on each push whose V=1, and saturates at 255.
  - clr_cnt has priority: if asserted, ovf_cnt becomes 0 that edge, even if a V=1 push occurs.
- in_valid while full: nothing is stored; upstream must hold the data.
- out_ready while empty: ignored.
- Reset (any time, including mid-transfer):
  - count, pointers and ovf_cnt → 0.
  - All storage → 0, so out_y=0, out_sel=0, out_flags=0.
  - out_valid=0, in_ready=1.
  - Contents in flight are discarded.

## Timing
- Latency: an entry pushed at edge k gives out_valid=1 with its data after edge k (visible in cycle k+1), when the queue was empty.
- There is no combinational path from in_* to out_* and none from out_ready to in_ready.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Reset is asserted asynchronously and deasserted synchronously to clk, using an external synchronizer.
- Outputs are stable between edges; flags are never recomputed after storage.

## Test plan
- ADD: a=0x7F, b=0x01, y=0x80, cout=0 pushed → next cycle out_y=0x80, flags {V=1,N=1,Z=0,C=0}, ovf_cnt=1.
- SUB: a=0x05, b=0x05, y=0x00, cout=0 → flags {0,0,1,0}. SUB a=0x03, b=0x05, y=0xFE, cout=1 → flags {0,1,0,1}. DEC a=0x80, y=0x7F → V=1.
- Fill with out_ready=0, DEPTH=4, pushing y=0x11,0x22,0x33,0x44 → count=4, in_ready=0. A fifth push of 0x55 held by upstream is not taken. Then raise out_ready → outputs 0x11,0x22,0x33,0x44 in order, then 0x55 after re-acceptance.
- Simultaneous traffic: with count=2, in_valid=1 and out_ready=1 for 10 cycles → count stays 2, order preserved across pointer wrap. When full, in_valid=1 and out_ready=1 → pop only, count goes 4→3.
- ovf_cnt: 260 pushes of INC a=0x7F → ovf_cnt saturates at 255. Then assert clr_cnt in the same cycle as a V=1 push → ovf_cnt=0.
- Reset mid-operation: with count=3, drop rst_n between edges → out_valid=0, count=0, out_y/out_flags=0, ovf_cnt=0 immediately. After release, the first push appears 1 cycle later.
